// File: rtl/sincn_pkg.sv
// Shared types and helpers for the sinc^N decimator: FSM states, legal
// parameter bounds, accumulator width rule and decimation-ratio clamp.
package sincn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 4;
  localparam int OUT_W_MIN = 8;
  localparam int OUT_W_MAX = 24;

  // Full scale D^N needs N*log2(D) bits; one extra bit keeps it representable.
  function automatic int acc_width(input int order, input int max_log2);
    return order * max_log2 + 1;
  endfunction

  function automatic logic [3:0] clamp_dec(input logic [3:0] v, input int lo, input int hi);
    if (int'(v) < lo) return 4'(lo);
    if (int'(v) > hi) return 4'(hi);
    return v;
  endfunction

endpackage

// File: rtl/sincn_integrator_chain.sv
// ORDER cascaded modulo-2^ACC_W accumulators fed by the 1-bit modulator
// stream, with synchronous clear and run enable.
module sincn_integrator_chain
  import sincn_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int ACC_W = 37
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] r_acc [ORDER];

  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) r_acc[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < ORDER; k++) r_acc[k] <= '0;
    end else if (i_en) begin
      r_acc[0] <= r_acc[0] + {{(ACC_W-1){1'b0}}, i_bit};
      for (int k = 1; k < ORDER; k++) r_acc[k] <= r_acc[k] + r_acc[k-1];
    end
  end

  assign o_acc = r_acc[ORDER-1];

endmodule

// File: rtl/sincn_decimator.sv
// Single-clock sinc^N decimator for a 1-bit sigma-delta stream with runtime
// power-of-two ratio, settle discard and valid/ready output with overrun.
// Optional macro SINCN_OFFSET_TRIM_EN adds a signed post-scale offset trim.
module sincn_decimator
  import sincn_pkg::*;
#(
  parameter int ORDER        = 3,
  parameter int OUT_W        = 16,
  parameter int MIN_DEC_LOG2 = 5,
  parameter int MAX_DEC_LOG2 = 12
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic             mdata1,
  input  logic             enable,
  input  logic [3:0]       dec_log2,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef SINCN_OFFSET_TRIM_EN
  ,
  input  logic [OUT_W-1:0] offset_trim
`endif
);

  localparam int ACC_W = acc_width(ORDER, MAX_DEC_LOG2);
  localparam int SW    = ACC_W + OUT_W;

  // Right shift for S>=0, left shift for S<0; exact full scale saturates.
  function automatic logic [OUT_W-1:0] scale_sat(input logic [ACC_W-1:0] r, input logic [3:0] dq);
    logic [SW-1:0] full;
    logic [SW-1:0] sh;
    int            amt;
    amt  = ORDER * int'(dq) - OUT_W;
    full = SW'(1) << (ORDER * int'(dq));
    sh   = SW'(r);
    if (sh >= full) return '1;
    if (amt >= 0) sh = sh >> amt;
    else          sh = sh << (-amt);
    return sh[OUT_W-1:0];
  endfunction

`ifdef SINCN_OFFSET_TRIM_EN
  function automatic logic [OUT_W-1:0] trim_sat(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] t);
    logic signed [OUT_W+1:0] sum;
    sum = $signed({2'b00, s}) + $signed({{2{t[OUT_W-1]}}, t});
    if (sum < 0) return '0;
    if (sum > $signed({2'b00, {OUT_W{1'b1}}})) return '1;
    return sum[OUT_W-1:0];
  endfunction
`endif

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_dec_q, w_dec_clamp;
  logic [MAX_DEC_LOG2-1:0] r_cnt, w_last;
  logic [2:0]              r_settle;
  logic                    w_start, w_run_int, w_frame_end, w_dec_chg;
  logic [ACC_W-1:0]        w_int_out;

  logic [ACC_W-1:0]        r_samp_p0;
  logic [3:0]              r_dq_p0;
  logic                    r_vld_p0, r_keep_p0;
  logic [ACC_W-1:0]        r_cdly [ORDER];
  logic [ACC_W-1:0]        w_comb [ORDER+1];
  logic [ACC_W-1:0]        r_res_p1;
  logic [3:0]              r_dq_p1;
  logic                    r_vld_p1;

  logic                    w_load;
  logic [OUT_W-1:0]        w_new;
  logic [OUT_W-1:0]        r_data_out;
  logic                    r_data_valid, r_overrun;

  assign w_dec_clamp = clamp_dec(dec_log2, MIN_DEC_LOG2, MAX_DEC_LOG2);
  assign w_last      = ~({MAX_DEC_LOG2{1'b1}} << r_dec_q);
  assign w_frame_end = (r_state != ST_IDLE) && (r_cnt == w_last);
  assign w_dec_chg   = w_frame_end && (w_dec_clamp != r_dec_q);
  assign w_start     = (r_state == ST_IDLE) && enable;
  assign w_run_int   = (r_state != ST_IDLE);

  sincn_integrator_chain #(
    .ORDER (ORDER),
    .ACC_W (ACC_W)
  ) u_int (
    .mclk1 (mclk1),
    .reset (reset),
    .i_clr (w_start),
    .i_en  (w_run_int),
    .i_bit (mdata1),
    .o_acc (w_int_out)
  );

  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (enable) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!enable) w_state_nxt = ST_IDLE;
        else if (w_frame_end && !w_dec_chg && (r_settle == 3'(ORDER-1))) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable)        w_state_nxt = ST_IDLE;
        else if (w_dec_chg) w_state_nxt = ST_SETTLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The ratio only changes on a frame boundary so a frame is never cut short.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_dec_q  <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
    end else begin
      if ((r_state == ST_IDLE) || w_frame_end) r_dec_q <= w_dec_clamp;
      if (w_start || w_frame_end) r_cnt <= '0;
      else if (r_state != ST_IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_start || w_dec_chg) r_settle <= '0;
      else if ((r_state == ST_SETTLE) && w_frame_end) r_settle <= r_settle + 1'b1;
    end
  end

  // Stage p0: frame-end capture of the last integrator with its ratio tag.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_samp_p0 <= '0;
      r_dq_p0   <= '0;
      r_vld_p0  <= 1'b0;
      r_keep_p0 <= 1'b0;
    end else begin
      r_vld_p0  <= w_frame_end;
      r_keep_p0 <= w_frame_end && (r_state == ST_RUN);
      if (w_start) r_samp_p0 <= '0;
      else if (w_frame_end) begin
        r_samp_p0 <= w_int_out;
        r_dq_p0   <= r_dec_q;
      end
    end
  end

  always_comb begin
    w_comb[0] = r_samp_p0;
    for (int k = 0; k < ORDER; k++) w_comb[k+1] = w_comb[k] - r_cdly[k];
  end

  // Stage p1: comb differences; combs advance on discarded frames too.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) r_cdly[k] <= '0;
      r_res_p1 <= '0;
      r_dq_p1  <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0 && r_keep_p0 && !w_start;
      if (w_start) begin
        for (int k = 0; k < ORDER; k++) r_cdly[k] <= '0;
      end else if (r_vld_p0) begin
        for (int k = 0; k < ORDER; k++) r_cdly[k] <= w_comb[k];
        r_res_p1 <= w_comb[ORDER];
        r_dq_p1  <= r_dq_p0;
      end
    end
  end

`ifdef SINCN_OFFSET_TRIM_EN
  logic [OUT_W-1:0] r_scaled_p2;
  logic             r_vld_p2;

  // Stage p2: saturated scale, trimmed on the way into the output register.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_scaled_p2 <= '0;
      r_vld_p2    <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_scaled_p2 <= scale_sat(r_res_p1, r_dq_p1);
    end
  end

  assign w_load = r_vld_p2;
  assign w_new  = trim_sat(r_scaled_p2, offset_trim);
`else
  assign w_load = r_vld_p1;
  assign w_new  = scale_sat(r_res_p1, r_dq_p1);
`endif

  // Output register: a new sample beats a same-edge accept; overrun set beats clear.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_data_out   <= w_new;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
      if (w_load && r_data_valid && !data_ready) r_overrun <= 1'b1;
      else if (overrun_clr)                      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sincn_decimator.sv
// Directed bench for sincn_decimator (ORDER=3, OUT_W=16): table of ratio /
// pattern vectors plus hand sequences for overrun, ratio change and reset.
module tb_sincn_decimator;

`ifdef SINCN_OFFSET_TRIM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        mclk1       = 1'b0;
  logic        reset       = 1'b1;
  logic        mdata1      = 1'b0;
  logic        enable      = 1'b0;
  logic [3:0]  dec_log2    = 4'd8;
  logic        data_ready  = 1'b1;
  logic        overrun_clr = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        overrun;
`ifdef SINCN_OFFSET_TRIM_EN
  logic [15:0] offset_trim = 16'hFFF0;
`endif

  int checks = 0;
  int errors = 0;
  int pat    = 0;

  always #5 mclk1 = ~mclk1;

  sincn_decimator #(
    .ORDER        (3),
    .OUT_W        (16),
    .MIN_DEC_LOG2 (5),
    .MAX_DEC_LOG2 (12)
  ) dut (
    .mclk1       (mclk1),
    .reset       (reset),
    .mdata1      (mdata1),
    .enable      (enable),
    .dec_log2    (dec_log2),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef SINCN_OFFSET_TRIM_EN
    ,
    .offset_trim (offset_trim)
`endif
  );

  // Modulator stream: 0 = all zeros, 1 = all ones, 2 = alternating.
  initial begin
    forever begin
      @(posedge mclk1);
      #2;
      case (pat)
        0:       mdata1 = 1'b0;
        1:       mdata1 = 1'b1;
        default: mdata1 = ~mdata1;
      endcase
    end
  end

  typedef struct {
    logic [3:0]  dec;
    int          pat;
    int          eff;
    logic [15:0] raw;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge mclk1);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!data_valid && n < max);
    if (!data_valid) n = -1;
  endtask

  task automatic restart(input logic [3:0] d, input int p);
    enable      = 1'b0;
    data_ready  = 1'b1;
    overrun_clr = 1'b0;
    reset       = 1'b1;
    pat         = p;
    dec_log2    = d;
    tick();
    tick();
    reset = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  function automatic logic [31:0] exp_val(input logic [15:0] e);
`ifdef SINCN_OFFSET_TRIM_EN
    int v;
    v = int'(e) - 16;
    if (v < 0) v = 0;
    return 32'(v);
`else
    return {16'h0, e};
`endif
  endfunction

  initial begin
    int n;
    int d;

    vt[0] = '{4'd8,  1, 8,  16'hFFFF};
    vt[1] = '{4'd8,  0, 8,  16'h0000};
    vt[2] = '{4'd8,  2, 8,  16'h8000};
    vt[3] = '{4'd5,  2, 5,  16'h8000};
    vt[4] = '{4'd5,  1, 5,  16'hFFFF};
    vt[5] = '{4'd4,  0, 5,  16'h0000};
    vt[6] = '{4'd6,  2, 6,  16'h8000};
    vt[7] = '{4'd15, 2, 12, 16'h8000};

    tick();
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_overrun", overrun, 0);

    for (int i = 0; i < 8; i++) begin
      d = 1 << vt[i].eff;
      restart(vt[i].dec, vt[i].pat);
      wait_valid(5 * d + 16, n);
      chk($sformatf("v%0d_first_latency", i), n, 4 * d + 1 + LAT);
      chk($sformatf("v%0d_first_value", i), data_out, exp_val(vt[i].raw));
      tick();
      chk($sformatf("v%0d_valid_pulse", i), data_valid, 0);
      wait_valid(2 * d, n);
      chk($sformatf("v%0d_period", i), n, d - 1);
      chk($sformatf("v%0d_second_value", i), data_out, exp_val(vt[i].raw));
    end

    // Overrun: hold off the consumer across frames, clear, accept, set-wins.
    restart(4'd5, 2);
    wait_valid(5 * 32 + 16, n);
    data_ready = 1'b0;
    repeat (31) tick();
    chk("ovr_before", overrun, 0);
    chk("ovr_valid_held", data_valid, 1);
    tick();
    chk("ovr_set", overrun, 1);
    chk("ovr_data", data_out, exp_val(16'h8000));
    repeat (32) tick();
    chk("ovr_valid_2frames", data_valid, 1);
    chk("ovr_sticky", overrun, 1);
    repeat (3) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    data_ready = 1'b1;
    tick();
    chk("accept_clears_valid", data_valid, 0);
    data_ready = 1'b0;
    repeat (27) tick();
    chk("load_after_accept_valid", data_valid, 1);
    chk("load_after_accept_no_ovr", overrun, 0);
    repeat (31) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_set_wins_clr", overrun, 1);

    // Ratio change 8 -> 6 mid-frame.
    restart(4'd8, 2);
    wait_valid(5 * 256 + 16, n);
    repeat (10) tick();
    dec_log2 = 4'd6;
    wait_valid(400, n);
    chk("chg_old_frame_end", n, 246);
    chk("chg_old_value", data_out, exp_val(16'h8000));
    wait_valid(400, n);
    chk("chg_settle_gap", n, 256);
    chk("chg_new_value", data_out, exp_val(16'h8000));
    wait_valid(200, n);
    chk("chg_new_period", n, 64);

    // Disable retains the pending sample; async reset clears at once.
    restart(4'd5, 2);
    wait_valid(5 * 32 + 16, n);
    data_ready = 1'b0;
    repeat (40) tick();
    enable = 1'b0;
    repeat (5) tick();
    chk("idle_valid_kept", data_valid, 1);
    chk("idle_data_kept", data_out, exp_val(16'h8000));
    repeat (60) tick();
    chk("idle_valid_still", data_valid, 1);
    chk("pre_reset_overrun", overrun, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_data_out", data_out, 0);
    chk("async_rst_valid", data_valid, 0);
    chk("async_rst_overrun", overrun, 0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
